// File: rtl/trigger_scaler_pkg.sv
// Shared widths and sample/beat types for the trigger hit scaler slice.
package trigger_scaler_pkg;

  localparam int NSAMP      = 8;
  localparam int SAMP_W     = 5;
  localparam int MAG_W      = 6;
  localparam int SQ_W       = 9;
  localparam int BEAT_PWR_W = 12;

  typedef logic signed [SAMP_W-1:0] sample_t;
  typedef sample_t [NSAMP-1:0]      beat_t;

endpackage

// File: rtl/trig_beat_power.sv
// Two-stage per-beat reduction: magnitudes and squares, then threshold hit and beat power.
module trig_beat_power
  import trigger_scaler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSAMP*SAMP_W-1:0] dat,
  input  logic                   vld_in,
  input  logic [SAMP_W-1:0]      thresh,
  output logic                   hit,
  output logic [BEAT_PWR_W-1:0]  beat_pwr,
  output logic                   vld_out
);

  beat_t           beat;
  logic [MAG_W-1:0] mag_c [NSAMP];
  logic [MAG_W-1:0] mag_q [NSAMP];
  logic [SQ_W-1:0]  sq_c  [NSAMP];
  logic [SQ_W-1:0]  sq_q  [NSAMP];
  logic [MAG_W-1:0] ext   [NSAMP];
  logic             vld1;
  logic             hit_c;
  logic [BEAT_PWR_W-1:0] pwr_c;

  assign beat = dat;

  // Sign-extend by one bit first so that -16 maps cleanly to magnitude 16.
  always_comb begin
    for (int unsigned k = 0; k < NSAMP; k++) begin
      ext[k]   = {beat[k][SAMP_W-1], beat[k]};
      mag_c[k] = ext[k][MAG_W-1] ? -ext[k] : ext[k];
      sq_c[k]  = SQ_W'(mag_c[k]) * SQ_W'(mag_c[k]);
    end
  end

  always_comb begin
    hit_c = 1'b0;
    pwr_c = '0;
    for (int unsigned k = 0; k < NSAMP; k++) begin
      hit_c = hit_c | (mag_q[k] > MAG_W'(thresh));
      pwr_c = pwr_c + BEAT_PWR_W'(sq_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSAMP; k++) begin
        mag_q[k] <= '0;
        sq_q[k]  <= '0;
      end
      vld1     <= 1'b0;
      hit      <= 1'b0;
      beat_pwr <= '0;
      vld_out  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NSAMP; k++) begin
        mag_q[k] <= mag_c[k];
        sq_q[k]  <= sq_c[k];
      end
      vld1     <= vld_in;
      hit      <= hit_c;
      beat_pwr <= pwr_c;
      vld_out  <= vld1 & vld_in;
    end
  end

endmodule

// File: rtl/trigger_hit_scaler.sv
// Threshold trigger with holdoff, plus gated saturating trigger scaler and power accumulator.
module trigger_hit_scaler
  import trigger_scaler_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PWR_W    = 32,
  parameter int PERIOD_W = 24
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NSAMP*SAMP_W-1:0] dat_i,
  input  logic                    enable_i,
  input  logic [SAMP_W-1:0]       thresh_i,
  input  logic [7:0]              holdoff_i,
  input  logic [PERIOD_W-1:0]     period_i,
  output logic                    trig_o,
  output logic [CNT_W-1:0]        count_o,
  output logic [PWR_W-1:0]        power_o,
  output logic                    stats_valid_o
);

  logic                  hit2;
  logic                  vld2;
  logic [BEAT_PWR_W-1:0] beat_pwr2;
  logic [7:0]            hold_cnt;
  logic [PERIOD_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]      acc_cnt;
  logic [PWR_W-1:0]      acc_pwr;
  logic [CNT_W-1:0]      cnt_next;
  logic [PWR_W:0]        pwr_sum;
  logic [PWR_W-1:0]      pwr_next;
  logic                  trig;
  logic                  terminal;

  trig_beat_power u_beat (
    .clk      (aclk),
    .rst_n    (aresetn),
    .dat      (dat_i),
    .vld_in   (enable_i),
    .thresh   (thresh_i),
    .hit      (hit2),
    .beat_pwr (beat_pwr2),
    .vld_out  (vld2)
  );

  // Decided combinationally off stage 2 so the pulse lands two cycles after the input beat.
  assign trig   = enable_i & vld2 & hit2 & (hold_cnt == '0);
  assign trig_o = trig;

  always_comb begin
    cnt_next = (acc_cnt == '1) ? acc_cnt : acc_cnt + CNT_W'(trig);
    pwr_sum  = {1'b0, acc_pwr} + (PWR_W+1)'(beat_pwr2);
    pwr_next = pwr_sum[PWR_W] ? '1 : pwr_sum[PWR_W-1:0];
    terminal = (beat_cnt >= period_i - PERIOD_W'(1));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_cnt <= '0;
    end else if (!enable_i) begin
      hold_cnt <= '0;
    end else if (trig) begin
      hold_cnt <= holdoff_i;
    end else if (vld2 && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt      <= '0;
      acc_cnt       <= '0;
      acc_pwr       <= '0;
      count_o       <= '0;
      power_o       <= '0;
      stats_valid_o <= 1'b0;
    end else begin
      stats_valid_o <= 1'b0;
      if (!enable_i || period_i == '0) begin
        beat_cnt <= '0;
        acc_cnt  <= '0;
        acc_pwr  <= '0;
      end else if (vld2) begin
        if (terminal) begin
          count_o       <= cnt_next;
          power_o       <= pwr_next;
          stats_valid_o <= 1'b1;
          beat_cnt      <= '0;
          acc_cnt       <= '0;
          acc_pwr       <= '0;
        end else begin
          beat_cnt <= beat_cnt + PERIOD_W'(1);
          acc_cnt  <= cnt_next;
          acc_pwr  <= pwr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_hit_scaler.sv
// Directed bench for trigger_hit_scaler; narrowed scaler/power widths keep saturation reachable.
module tb_trigger_hit_scaler;

  localparam int CNT_W    = 8;
  localparam int PWR_W    = 16;
  localparam int PERIOD_W = 24;

  logic                aclk;
  logic                aresetn;
  logic [39:0]         dat_i;
  logic                enable_i;
  logic [4:0]          thresh_i;
  logic [7:0]          holdoff_i;
  logic [PERIOD_W-1:0] period_i;
  logic                trig_o;
  logic [CNT_W-1:0]    count_o;
  logic [PWR_W-1:0]    power_o;
  logic                stats_valid_o;

  int vectors    = 0;
  int miscompares = 0;

  trigger_hit_scaler #(
    .CNT_W    (CNT_W),
    .PWR_W    (PWR_W),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .dat_i         (dat_i),
    .enable_i      (enable_i),
    .thresh_i      (thresh_i),
    .holdoff_i     (holdoff_i),
    .period_i      (period_i),
    .trig_o        (trig_o),
    .count_o       (count_o),
    .power_o       (power_o),
    .stats_valid_o (stats_valid_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [39:0] fill(input logic [4:0] v);
    return {8{v}};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, output int trigs, output int stats);
    trigs = 0;
    stats = 0;
    for (int i = 0; i < n; i++) begin
      step();
      trigs += int'(trig_o);
      stats += int'(stats_valid_o);
    end
  endtask

  task automatic wait_stats(input int bound, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!stats_valid_o && waited < bound);
  endtask

  initial begin
    int t, s, w;
    logic [39:0] d;
    logic [19:0] pat;

    aresetn   = 1'b0;
    enable_i  = 1'b0;
    dat_i     = '0;
    thresh_i  = 5'd5;
    holdoff_i = 8'd0;
    period_i  = '0;
    step();
    step();
    chk("rst_trig",  32'(trig_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_power", 32'(power_o), 32'd0);
    chk("rst_valid", 32'(stats_valid_o), 32'd0);
    aresetn  = 1'b1;
    enable_i = 1'b1;

    // Threshold boundary: magnitude equal to threshold must not hit
    dat_i = fill(5'd5);
    run(6, t, s);
    chk("thr_eq_notrig", 32'(t), 32'd0);

    d = fill(5'd5);
    d[15 +: 5] = 5'b11010;
    dat_i = d;
    step();
    chk("thr_lat_n1", 32'(trig_o), 32'd0);
    dat_i = fill(5'd5);
    step();
    chk("thr_lat_n2", 32'(trig_o), 32'd1);
    run(6, t, s);
    chk("thr_single", 32'(t), 32'd0);

    thresh_i = 5'd16;
    dat_i    = fill(5'b10000);
    run(8, t, s);
    chk("thr16_never", 32'(t), 32'd0);

    dat_i = '0;
    run(4, t, s);

    // Holdoff 3 with continuous hits
    thresh_i  = 5'd5;
    holdoff_i = 8'd3;
    dat_i     = fill(5'b10000);
    step();
    for (int j = 0; j < 20; j++) begin
      step();
      pat[j] = trig_o;
    end
    chk("holdoff_pattern", 32'(pat), 32'h11111);
    dat_i     = '0;
    holdoff_i = 8'd0;
    run(6, t, s);

    // Gate of 10 beats, every beat a full-scale hit
    thresh_i = 5'd0;
    period_i = 24'd10;
    dat_i    = fill(5'b10000);
    wait_stats(30, w);
    wait_stats(30, w);
    chk("gate_valid", 32'(stats_valid_o), 32'd1);
    chk("gate_interval", 32'(w), 32'd10);
    chk("gate_count", 32'(count_o), 32'd10);
    chk("gate_power", 32'(power_o), 32'd20480);

    dat_i = '0;
    wait_stats(30, w);
    wait_stats(30, w);
    chk("zero_valid", 32'(stats_valid_o), 32'd1);
    chk("zero_count", 32'(count_o), 32'd0);
    chk("zero_power", 32'(power_o), 32'd0);

    // Enable dropped mid-period, then re-enabled with quiet data
    dat_i = fill(5'b10000);
    wait_stats(30, w);
    wait_stats(30, w);
    chk("pre_dis_count", 32'(count_o), 32'd10);
    run(4, t, s);
    enable_i = 1'b0;
    #1;
    chk("dis_trig_now", 32'(trig_o), 32'd0);
    run(15, t, s);
    chk("dis_trigs", 32'(t), 32'd0);
    chk("dis_stats", 32'(s), 32'd0);
    chk("dis_count_held", 32'(count_o), 32'd10);
    chk("dis_power_held", 32'(power_o), 32'd20480);
    dat_i    = '0;
    enable_i = 1'b1;
    wait_stats(30, w);
    chk("reen_valid", 32'(stats_valid_o), 32'd1);
    chk("reen_count", 32'(count_o), 32'd0);
    chk("reen_power", 32'(power_o), 32'd0);

    // Period shrunk from 100 to 5 after 50 beats closes on the next beat
    dat_i    = fill(5'b10000);
    period_i = 24'd100;
    wait_stats(200, w);
    chk("p100_valid", 32'(stats_valid_o), 32'd1);
    run(50, t, s);
    chk("p100_no_stats", 32'(s), 32'd0);
    period_i = 24'd5;
    step();
    chk("shrink_valid", 32'(stats_valid_o), 32'd1);
    chk("shrink_count", 32'(count_o), 32'd51);
    chk("shrink_power", 32'(power_o), 32'hFFFF);

    // Saturation over a long gate
    period_i = 24'hFFFFFF;
    run(300, t, s);
    chk("sat_no_stats", 32'(s), 32'd0);
    period_i = 24'd1;
    step();
    chk("sat_valid", 32'(stats_valid_o), 32'd1);
    chk("sat_count", 32'(count_o), 32'hFF);
    chk("sat_power", 32'(power_o), 32'hFFFF);
    step();
    chk("p1_valid", 32'(stats_valid_o), 32'd1);
    chk("p1_count", 32'(count_o), 32'd1);
    chk("p1_power", 32'(power_o), 32'd2048);

    // Asynchronous reset mid-stream
    #3;
    aresetn = 1'b0;
    #1;
    chk("areset_trig",  32'(trig_o), 32'd0);
    chk("areset_count", 32'(count_o), 32'd0);
    chk("areset_power", 32'(power_o), 32'd0);
    chk("areset_valid", 32'(stats_valid_o), 32'd0);
    #1;
    aresetn = 1'b1;
    #1;
    chk("rel_c0_trig", 32'(trig_o), 32'd0);
    step();
    chk("rel_c1_trig",  32'(trig_o), 32'd0);
    chk("rel_c1_valid", 32'(stats_valid_o), 32'd0);
    step();
    chk("rel_c2_trig",  32'(trig_o), 32'd1);
    chk("rel_c2_valid", 32'(stats_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
